// File: rtl/ii_capture.sv
// Streaming integral-image generator: OV7670 byte stream in, one (address, ii) buffer write per Y byte out.
// Keeps a one-row line buffer of integral values and a running sum for the current row.
module ii_capture #(
   parameter int unsigned IMG_W  = 160,
   parameter int unsigned IMG_H  = 120,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 15
) (
   input  logic              ov7670_pclk,
   input  logic              rst,
   input  logic              ov7670_vsync,
   input  logic              ov7670_href,
   input  logic [7:0]        ov7670_data,
   output logic              we,
   output logic [ADDR_W-1:0] ii_address,
   output logic [DATA_W-1:0] ii_wrdata
);

   localparam int unsigned COL_W = $clog2(IMG_W + 1);
   localparam int unsigned ROW_W = $clog2(IMG_H + 1);

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              phase_q, phase_d;
   logic              href_q, href_d;
   logic [DATA_W-1:0] row_sum_q, row_sum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   // ii of the previous row; never reset, row 0 ignores it
   logic [DATA_W-1:0] prev_mem [IMG_W];

   logic              col_ok_c;
   logic              row_ok_c;
   logic              accept_c;
   logic [COL_W-1:0]  col_idx_c;
   logic [DATA_W-1:0] prev_rd_c;
   logic [DATA_W-1:0] y_ext_c;
   logic [DATA_W-1:0] pix_sum_c;
   logic [ADDR_W-1:0] pix_addr_c;

   // Pixel acceptance and integral value for the current Y byte
   always_comb begin
      col_ok_c   = (col_q < COL_W'(IMG_W));
      row_ok_c   = (row_q < ROW_W'(IMG_H));
      accept_c   = !ov7670_vsync && ov7670_href && !phase_q && col_ok_c && row_ok_c;
      col_idx_c  = col_ok_c ? col_q : '0;
      prev_rd_c  = (row_q == '0) ? '0 : prev_mem[col_idx_c];
      y_ext_c    = DATA_W'(ov7670_data);
      pix_sum_c  = row_sum_q + y_ext_c + prev_rd_c;
      pix_addr_c = (ADDR_W'(row_q) * ADDR_W'(IMG_W)) + ADDR_W'(col_q);
   end

   // Next-state logic: vsync clears the frame, href falling edge advances the row
   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      phase_d   = phase_q;
      href_d    = href_q;
      row_sum_d = row_sum_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;

      if (ov7670_vsync) begin
         col_d     = '0;
         row_d     = '0;
         phase_d   = 1'b0;
         href_d    = 1'b0;
         row_sum_d = '0;
      end else begin
         href_d = ov7670_href;
         if (ov7670_href) begin
            phase_d = ~phase_q;
            if (accept_c) begin
               we_d      = 1'b1;
               addr_d    = pix_addr_c;
               data_d    = pix_sum_c;
               row_sum_d = row_sum_q + y_ext_c;
               col_d     = col_q + COL_W'(1);
            end
         end else begin
            phase_d = 1'b0;
            if (href_q) begin
               if (row_ok_c) begin
                  row_d = row_q + ROW_W'(1);
               end
               col_d     = '0;
               row_sum_d = '0;
            end
         end
      end
   end

   always_ff @(posedge ov7670_pclk or posedge rst) begin
      if (rst) begin
         col_q     <= '0;
         row_q     <= '0;
         phase_q   <= 1'b0;
         href_q    <= 1'b0;
         row_sum_q <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         phase_q   <= phase_d;
         href_q    <= href_d;
         row_sum_q <= row_sum_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   // Line buffer update, written in step with the output write
   always_ff @(posedge ov7670_pclk) begin
      if (accept_c) begin
         prev_mem[col_idx_c] <= pix_sum_c;
      end
   end

   assign we         = we_q;
   assign ii_address = addr_q;
   assign ii_wrdata  = data_q;

endmodule

// File: tb/tb_ii_capture.sv
// Directed bench for ii_capture: constant, ramp, long-line, vsync-restart and mid-line reset frames.
module tb_ii_capture;

   localparam int NPIX = 19200;

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync;
   logic        href;
   logic [7:0]  data;
   logic        we;
   logic [14:0] ii_address;
   logic [31:0] ii_wrdata;

   int total = 0;
   int bad   = 0;

   // Write log filled from the DUT outputs, inspected by the test tasks
   logic [31:0] img [0:NPIX-1];
   int          wr_cnt    = 0;
   int          mono_bad  = 0;
   int          dbl_bad   = 0;
   int          hi_bad    = 0;
   int          hold_bad  = 0;
   int          last_addr = -1;
   logic [31:0] last_data = '0;
   logic        we_prev   = 1'b0;
   logic [14:0] seen_addr = '0;
   logic [31:0] seen_data = '0;

   ii_capture dut (
      .ov7670_pclk (clk),
      .rst         (rst),
      .ov7670_vsync(vsync),
      .ov7670_href (href),
      .ov7670_data (data),
      .we          (we),
      .ii_address  (ii_address),
      .ii_wrdata   (ii_wrdata)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we) begin
         wr_cnt++;
         if (we_prev) dbl_bad++;
         if (ii_wrdata[31:23] != 9'd0) hi_bad++;
         if (int'(ii_address) < NPIX) img[ii_address] = ii_wrdata;
         if ((int'(ii_address) % 160) != 0 && ii_wrdata < last_data) mono_bad++;
         last_addr = int'(ii_address);
         last_data = ii_wrdata;
      end else if (!rst && (ii_address !== seen_addr || ii_wrdata !== seen_data)) begin
         hold_bad++;
      end
      we_prev   = we;
      seen_addr = ii_address;
      seen_data = ii_wrdata;
   end

   task automatic clear_log();
      for (int i = 0; i < NPIX; i++) img[i] = 32'hDEAD_BEEF;
   endtask

   task automatic start_frame();
      @(negedge clk);
      href  = 1'b0;
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      vsync = 1'b0;
   endtask

   task automatic send_pixel(input logic [7:0] y);
      @(negedge clk);
      href = 1'b1;
      data = y;
      @(negedge clk);
      data = 8'h80;
   endtask

   task automatic end_line();
      @(negedge clk);
      href = 1'b0;
      data = 8'h00;
      @(negedge clk);
   endtask

   task automatic send_line(input int npix, input logic [7:0] y, input bit ramp);
      for (int c = 0; c < npix; c++) send_pixel(ramp ? 8'(c) : y);
      end_line();
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      vsync = 1'b0;
      href  = 1'b0;
      data  = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
      total++; if (ii_address !== 15'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", ii_address); end
      total++; if (ii_wrdata !== 32'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", ii_wrdata); end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      total++; if (wr_cnt !== 0) begin bad++; $display("FAIL reset_nowrite got=%0d exp=0", wr_cnt); end
   endtask

   task automatic test_const(input logic [7:0] y, input string nm);
      int w0;
      int e;
      int k;
      k  = int'(y);
      clear_log();
      w0 = wr_cnt;
      start_frame();
      for (int r = 0; r < 120; r++) send_line(160, y, 1'b0);
      #1;
      total++; if (wr_cnt - w0 !== 19200) begin bad++; $display("FAIL %s_count got=%0d exp=19200", nm, wr_cnt - w0); end
      total++; if (img[0] !== 32'(k)) begin bad++; $display("FAIL %s_a0 got=%0d exp=%0d", nm, img[0], k); end
      total++; if (img[159] !== 32'(160 * k)) begin bad++; $display("FAIL %s_a159 got=%0d exp=%0d", nm, img[159], 160 * k); end
      total++; if (img[160] !== 32'(2 * k)) begin bad++; $display("FAIL %s_a160 got=%0d exp=%0d", nm, img[160], 2 * k); end
      total++; if (last_addr !== 19199) begin bad++; $display("FAIL %s_last_addr got=%0d exp=19199", nm, last_addr); end
      total++; if (last_data !== 32'(19200 * k)) begin bad++; $display("FAIL %s_last_data got=%0d exp=%0d", nm, last_data, 19200 * k); end
      e = 0;
      for (int r = 0; r < 120; r++)
         for (int c = 0; c < 160; c++)
            if (img[r * 160 + c] !== 32'(k * (c + 1) * (r + 1))) e++;
      total++; if (e !== 0) begin bad++; $display("FAIL %s_image got=%0d_wrong exp=0_wrong", nm, e); end
      total++; if (hi_bad !== 0) begin bad++; $display("FAIL %s_high_bits got=%0d exp=0", nm, hi_bad); end
      total++; if (mono_bad !== 0) begin bad++; $display("FAIL %s_monotonic got=%0d exp=0", nm, mono_bad); end
      total++; if (dbl_bad !== 0) begin bad++; $display("FAIL %s_we_pulse got=%0d exp=0", nm, dbl_bad); end
      total++; if (hold_bad !== 0) begin bad++; $display("FAIL %s_hold got=%0d exp=0", nm, hold_bad); end
   endtask

   task automatic test_ramp();
      clear_log();
      start_frame();
      send_line(160, 8'd0, 1'b1);
      send_line(160, 8'd0, 1'b1);
      #1;
      total++; if (img[0] !== 32'd0) begin bad++; $display("FAIL ramp_a0 got=%0d exp=0", img[0]); end
      total++; if (img[10] !== 32'd55) begin bad++; $display("FAIL ramp_a10 got=%0d exp=55", img[10]); end
      total++; if (img[159] !== 32'd12720) begin bad++; $display("FAIL ramp_a159 got=%0d exp=12720", img[159]); end
      total++; if (img[170] !== 32'd110) begin bad++; $display("FAIL ramp_a170 got=%0d exp=110", img[170]); end
      total++; if (img[319] !== 32'd25440) begin bad++; $display("FAIL ramp_a319 got=%0d exp=25440", img[319]); end
      total++; if (mono_bad !== 0) begin bad++; $display("FAIL ramp_monotonic got=%0d exp=0", mono_bad); end
   endtask

   task automatic test_long_line();
      int w0;
      clear_log();
      w0 = wr_cnt;
      start_frame();
      send_line(200, 8'd1, 1'b0);
      #1;
      total++; if (wr_cnt - w0 !== 160) begin bad++; $display("FAIL long_count got=%0d exp=160", wr_cnt - w0); end
      total++; if (last_addr !== 159) begin bad++; $display("FAIL long_last_addr got=%0d exp=159", last_addr); end
      total++; if (last_data !== 32'd160) begin bad++; $display("FAIL long_last_data got=%0d exp=160", last_data); end
      send_line(160, 8'd2, 1'b0);
      #1;
      total++; if (img[160] !== 32'd3) begin bad++; $display("FAIL long_next_a160 got=%0d exp=3", img[160]); end
      total++; if (img[319] !== 32'd480) begin bad++; $display("FAIL long_next_a319 got=%0d exp=480", img[319]); end
      total++; if (wr_cnt - w0 !== 320) begin bad++; $display("FAIL long_count2 got=%0d exp=320", wr_cnt - w0); end
   endtask

   task automatic test_vsync_restart();
      int w0;
      start_frame();
      for (int r = 0; r < 50; r++) send_line(2, 8'd3, 1'b0);
      send_pixel(8'd3);
      @(negedge clk);
      #1;
      total++; if (last_addr !== 8000) begin bad++; $display("FAIL vs_row50_addr got=%0d exp=8000", last_addr); end
      total++; if (last_data !== 32'd153) begin bad++; $display("FAIL vs_row50_data got=%0d exp=153", last_data); end
      w0 = wr_cnt;
      vsync = 1'b1;
      data  = 8'd3;
      repeat (4) begin
         @(negedge clk);
         data = ~data;
      end
      href = 1'b0;
      @(negedge clk);
      vsync = 1'b0;
      #1;
      total++; if (wr_cnt !== w0) begin bad++; $display("FAIL vs_nowrite got=%0d exp=%0d", wr_cnt, w0); end
      send_line(1, 8'd7, 1'b0);
      #1;
      total++; if (last_addr !== 0) begin bad++; $display("FAIL vs_first_addr got=%0d exp=0", last_addr); end
      total++; if (last_data !== 32'd7) begin bad++; $display("FAIL vs_first_data got=%0d exp=7", last_data); end
      send_line(1, 8'd7, 1'b0);
      #1;
      total++; if (last_addr !== 160) begin bad++; $display("FAIL vs_row1_addr got=%0d exp=160", last_addr); end
      total++; if (last_data !== 32'd14) begin bad++; $display("FAIL vs_row1_data got=%0d exp=14", last_data); end
   endtask

   task automatic test_reset_midline();
      int w0;
      start_frame();
      for (int c = 0; c < 40; c++) send_pixel(8'd1);
      @(negedge clk);
      data = 8'd1;
      @(posedge clk);
      #2;
      total++; if (we !== 1'b1 || ii_address !== 15'd40 || ii_wrdata !== 32'd41) begin
         bad++; $display("FAIL mid_pre we=%b addr=%0d data=%0d exp=1/40/41", we, ii_address, ii_wrdata);
      end
      rst = 1'b1;
      #1;
      total++; if (we !== 1'b0) begin bad++; $display("FAIL mid_rst_we got=%b exp=0", we); end
      total++; if (ii_address !== 15'd0) begin bad++; $display("FAIL mid_rst_addr got=%0d exp=0", ii_address); end
      total++; if (ii_wrdata !== 32'd0) begin bad++; $display("FAIL mid_rst_data got=%0d exp=0", ii_wrdata); end
      w0 = wr_cnt;
      repeat (4) begin
         @(negedge clk);
         data = ~data;
      end
      @(negedge clk);
      rst  = 1'b0;
      href = 1'b0;
      #1;
      total++; if (wr_cnt !== w0) begin bad++; $display("FAIL mid_rst_nowrite got=%0d exp=%0d", wr_cnt, w0); end
      clear_log();
      w0 = wr_cnt;
      start_frame();
      for (int r = 0; r < 3; r++) send_line(160, 8'd1, 1'b0);
      #1;
      total++; if (wr_cnt - w0 !== 480) begin bad++; $display("FAIL mid_after_count got=%0d exp=480", wr_cnt - w0); end
      total++; if (img[0] !== 32'd1) begin bad++; $display("FAIL mid_after_a0 got=%0d exp=1", img[0]); end
      total++; if (img[159] !== 32'd160) begin bad++; $display("FAIL mid_after_a159 got=%0d exp=160", img[159]); end
      total++; if (img[160] !== 32'd2) begin bad++; $display("FAIL mid_after_a160 got=%0d exp=2", img[160]); end
      total++; if (img[479] !== 32'd480) begin bad++; $display("FAIL mid_after_a479 got=%0d exp=480", img[479]); end
   endtask

   initial begin
      test_reset();
      test_const(8'd1, "const1");
      test_const(8'd255, "const255");
      test_ramp();
      test_long_line();
      test_vsync_restart();
      test_reset_midline();
      total++; if (dbl_bad !== 0 || hold_bad !== 0) begin
         bad++; $display("FAIL final_pulse_hold dbl=%0d hold=%0d exp=0/0", dbl_bad, hold_bad);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
